alu_ctrl_mdu: RTL and testbench

Parametrised EX-stage ALU control unit. It decodes ALUOp and instruction fields into the 4-bit ALU Select, and adds RV32M support through an iterative multiply/divide sequencer. M-extension instructions stall the pipeline until the sequencer returns a result. The block sits between decode/ID-EX registers and the ALU/EX result mux.

---
 rtl/alu_ctrl_pkg.sv | 36 +++
 rtl/alu_ctrl_mdu_md_iter_core.sv | 56 +++++
 rtl/alu_ctrl_mdu.sv | 151 +++++++++++++++
 tb/tb_alu_ctrl_mdu.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control and the RV32M multiply/divide sequencer.
package alu_ctrl_pkg;

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_LUI  = 4'b0011;
  localparam logic [3:0] SEL_OR   = 4'b0100;
  localparam logic [3:0] SEL_AND  = 4'b0101;
  localparam logic [3:0] SEL_XOR  = 4'b0111;
  localparam logic [3:0] SEL_SLL  = 4'b1000;
  localparam logic [3:0] SEL_SRL  = 4'b1001;
  localparam logic [3:0] SEL_SRA  = 4'b1010;
  localparam logic [3:0] SEL_SLT  = 4'b1101;
  localparam logic [3:0] SEL_SLTU = 4'b1111;
  localparam logic [3:0] SEL_DEF  = 4'b0010;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_LUI  = 2'b11;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

endpackage

// File: rtl/alu_ctrl_mdu_md_iter_core.sv
// Iterative unsigned datapath: one shift-add (multiply) or restoring-divide step per cycle.
module md_iter_core
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              last,
  output logic [2*XLEN-1:0] acc_next
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   b_q;
  logic [CW-1:0]     count;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rs;
  logic [XLEN:0]     diff;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    rs   = acc[2*XLEN-1:XLEN-1];
    diff = rs - {1'b0, b_q};
    if (div)
      acc_next = diff[XLEN] ? {rs[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_next = {sum, acc[XLEN-1:1]};
  end

  assign last = (count == CW'(XLEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      b_q   <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= {{XLEN{1'b0}}, a};
      b_q   <= b;
      count <= '0;
    end else if (step) begin
      acc   <= acc_next;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control: base ALU select decode plus an iterative RV32M sequencer that stalls the pipe.
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      ALUOp,
  input  logic [31:0]     InReg,
  input  logic            ALUSrc,
  input  logic            valid,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [3:0]      Select,
  output logic [XLEN-1:0] md_result,
  output logic            md_done,
  output logic            stall
);

  md_state_t         state;
  logic [2:0]        funct3;
  logic [2:0]        f3_q;
  logic              is_md, accept;
  logic              neg_a, neg_b, neg_a_q, neg_b_q;
  logic              div_zero, div_ovf, core_last;
  logic [XLEN-1:0]   mag_a, mag_b, special_res, final_res, quo, rem;
  logic [2*XLEN-1:0] acc_next, prod;
  logic              unused_fields;

  assign funct3        = InReg[14:12];
  assign is_md         = ENABLE_M && (ALUOp == ALUOP_FUNC) && !ALUSrc &&
                         (InReg[6:0] == OPC_OP) && (InReg[31:25] == F7_MULDIV);
  assign accept        = valid && is_md && !flush;
  assign unused_fields = ^{InReg[24:15], InReg[11:7]};

  always_comb begin
    Select = SEL_DEF;
    if (!is_md) begin
      unique case (ALUOp)
        ALUOP_ADD: Select = SEL_ADD;
        ALUOP_SUB: Select = SEL_SUB;
        ALUOP_LUI: Select = SEL_LUI;
        default: begin
          unique case (funct3)
            3'b000:  Select = (InReg[30] && !ALUSrc) ? SEL_SUB : SEL_ADD;
            3'b001:  Select = SEL_SLL;
            3'b010:  Select = SEL_SLT;
            3'b011:  Select = SEL_SLTU;
            3'b100:  Select = SEL_XOR;
            3'b101:  Select = InReg[30] ? SEL_SRA : SEL_SRL;
            3'b110:  Select = SEL_OR;
            default: Select = SEL_AND;
          endcase
        end
      endcase
    end
  end

  // The core works on magnitudes; signs are reapplied when the result is captured.
  always_comb begin
    neg_a    = rs1_val[XLEN-1] && (funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    neg_b    = rs2_val[XLEN-1] && (funct3 inside {F3_MULH, F3_DIV, F3_REM});
    mag_a    = neg_a ? -rs1_val : rs1_val;
    mag_b    = neg_b ? -rs2_val : rs2_val;
    div_zero = funct3[2] && (rs2_val == '0);
    div_ovf  = funct3[2] && !funct3[0] &&
               (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
    if (div_zero) special_res = funct3[1] ? rs1_val : '1;
    else          special_res = funct3[1] ? '0 : rs1_val;
  end

  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -acc_next : acc_next;
    quo  = acc_next[XLEN-1:0];
    rem  = acc_next[2*XLEN-1:XLEN];
    unique case (f3_q)
      F3_MUL:                       final_res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_res = (neg_a_q ^ neg_b_q) ? -quo : quo;
      default:                      final_res = neg_a_q ? -rem : rem;
    endcase
  end

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == IDLE) && accept),
    .step     ((state == BUSY) && !flush),
    .div      (f3_q[2]),
    .a        (mag_a),
    .b        (mag_b),
    .last     (core_last),
    .acc_next (acc_next)
  );

  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE:    stall = accept;
        BUSY:    stall = !flush;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      f3_q      <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      md_result <= '0;
      md_done   <= 1'b0;
    end else begin
      md_done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              f3_q    <= funct3;
              neg_a_q <= neg_a;
              neg_b_q <= neg_b;
              if (div_zero || div_ovf) begin
                state     <= DONE;
                md_result <= special_res;
                md_done   <= 1'b1;
              end else begin
                state <= BUSY;
              end
            end
          end
          BUSY: begin
            if (core_last) begin
              state     <= DONE;
              md_result <= final_res;
              md_done   <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Scoreboard bench for alu_ctrl_mdu: random decode and M ops against a 64-bit arithmetic model.
module tb_alu_ctrl_mdu;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ALUOp;
  logic [31:0] InReg;
  logic        ALUSrc, valid, flush;
  logic [31:0] rs1_val, rs2_val;
  logic [3:0]  Select, Select0;
  logic [31:0] md_result, md_result0;
  logic        md_done, md_done0, stall, stall0;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  int unsigned cyc    = 0;

  typedef struct {
    logic [31:0] res;
    int unsigned due;
    string       tag;
  } exp_t;
  exp_t sb[$];

  alu_ctrl_mdu #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst(rst), .ALUOp(ALUOp), .InReg(InReg), .ALUSrc(ALUSrc),
    .valid(valid), .flush(flush), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .Select(Select), .md_result(md_result), .md_done(md_done), .stall(stall)
  );

  alu_ctrl_mdu #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .ALUOp(ALUOp), .InReg(InReg), .ALUSrc(ALUSrc),
    .valid(valid), .flush(flush), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .Select(Select0), .md_result(md_result0), .md_done(md_done0), .stall(stall0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] ref_sel(input logic [1:0] op, input logic [31:0] ir,
                                         input logic src, input bit m_en);
    if (m_en && op == 2'b10 && !src && ir[6:0] == 7'h33 && ir[31:25] == 7'h01) return 4'b0010;
    case (op)
      2'b00: return 4'b0000;
      2'b01: return 4'b0001;
      2'b11: return 4'b0011;
      default:
        case (ir[14:12])
          3'd0:    return (ir[30] && !src) ? 4'b0001 : 4'b0000;
          3'd1:    return 4'b1000;
          3'd2:    return 4'b1101;
          3'd3:    return 4'b1111;
          3'd4:    return 4'b0111;
          3'd5:    return ir[30] ? 4'b1010 : 4'b1001;
          3'd6:    return 4'b0100;
          default: return 4'b0101;
        endcase
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa  = longint'($signed(a));
    longint      sbv = longint'($signed(b));
    longint      ua  = longint'({32'b0, a});
    longint      ub  = longint'({32'b0, b});
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    logic [31:0] r;
    case (f3)
      3'd0: begin p = 64'(ua * ub);  r = p[31:0];  end
      3'd1: begin p = 64'(sa * sbv); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub);  r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub);  r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sbv);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sbv);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int unsigned ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] enc_md(input logic [2:0] f3);
    logic [4:0] r1 = 5'($urandom);
    logic [4:0] r2 = 5'($urandom);
    logic [4:0] rd = 5'($urandom);
    return {7'h01, r2, r1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic push_exp(input logic [2:0] f3, input string tag);
    exp_t e;
    e.res = ref_md(f3, rs1_val, rs2_val);
    e.due = cyc + ref_lat(f3, rs1_val, rs2_val);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic start_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input string tag);
    ALUOp = 2'b10; ALUSrc = 1'b0; InReg = enc_md(f3);
    rs1_val = a; rs2_val = b; valid = 1'b1; flush = 1'b0;
    #1;
    check({tag, " stall_at_issue"}, 32'(stall), 32'd1);
    check({tag, " select_md"}, 32'(Select), 32'h2);
    check({tag, " nom_stall"}, 32'(stall0 | md_done0), 32'd0);
    if (push) push_exp(f3, tag);
  endtask

  task automatic wait_done(input string tag, input int unsigned exp_stalls);
    int unsigned n = 1;
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (md_done) begin
        check({tag, " stall_at_done"}, 32'(stall), 32'd0);
        seen  = 1'b1;
        valid = 1'b0;
        break;
      end
      if (stall) n++;
      valid = 1'($urandom_range(0, 1));
    end
    valid = 1'b0;
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " stall_cycles"}, n, exp_stalls);
  endtask

  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge clk);
    start_md(f3, a, b, 1'b1, tag);
    wait_done(tag, ref_lat(f3, a, b));
  endtask

  task automatic apply_dec(input logic [1:0] op, input logic [31:0] ir, input logic src, input string tag);
    @(negedge clk);
    ALUOp = op; InReg = ir; ALUSrc = src;
    #1;
    check({tag, " select"}, 32'(Select), 32'(ref_sel(op, ir, src, 1'b1)));
    check({tag, " select_nom"}, 32'(Select0), 32'(ref_sel(op, ir, src, 1'b0)));
    check({tag, " stall"}, 32'(stall), 32'd0);
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (md_done) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_done: strobe with result 0x%08h at cycle %0d, required none", md_result, cyc);
        end else begin
          e = sb.pop_front();
          check({e.tag, " result"}, md_result, e.res);
          check({e.tag, " done_cycle"}, cyc, e.due);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ir;
    rst = 1'b1; ALUOp = 2'b00; InReg = '0; ALUSrc = 1'b0;
    valid = 1'b0; flush = 1'b0; rs1_val = '0; rs2_val = '0;
    #1;
    check("reset stall", 32'(stall), 32'd0);
    check("reset md_done", 32'(md_done), 32'd0);
    check("reset md_result", md_result, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Base decode: directed corners then random instruction words (valid low, nothing starts).
    apply_dec(2'b10, 32'h4000_0033, 1'b0, "dec_sub");
    check("dec_sub const", 32'(Select), 32'h1);
    apply_dec(2'b10, 32'h4000_0033, 1'b1, "dec_addi");
    check("dec_addi const", 32'(Select), 32'h0);
    apply_dec(2'b10, 32'h4000_5033, 1'b0, "dec_sra");
    check("dec_sra const", 32'(Select), 32'hA);
    valid = 1'b1;
    apply_dec(2'b10, 32'h4000_0033, 1'b0, "dec_sub_valid");
    valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ir = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ir[6:0]   = 7'h33;
        ir[31:25] = 7'h01;
      end
      apply_dec(2'($urandom), ir, 1'($urandom), $sformatf("dec_rand%0d", i));
    end

    // Directed M operations.
    run_md(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
    run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
    run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ones");
    run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
    run_md(3'd4, 32'd5, 32'd0, "div_by0");
    run_md(3'd6, 32'd5, 32'd0, "rem_by0");
    run_md(3'd5, 32'd5, 32'd0, "divu_by0");
    run_md(3'd7, 32'd5, 32'd0, "remu_by0");
    run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_md(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_md(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");

    for (int i = 0; i < 24; i++)
      run_md(3'($urandom), pick_operand(), pick_operand(), $sformatf("md_rand%0d", i));

    // Flush ten cycles into BUSY: no strobe, then a fresh MUL at N+12.
    @(negedge clk);
    start_md(3'd0, $urandom, $urandom, 1'b0, "flush_op");
    repeat (10) begin
      @(negedge clk); #1;
      valid = 1'b0;
    end
    flush = 1'b1;
    #1;
    check("flush stall_same_cycle", 32'(stall), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush idle_after", 32'(stall), 32'd0);
    run_md(3'd0, $urandom, $urandom, "mul_after_flush");

    // Reset mid-BUSY with the M instruction still presented.
    @(negedge clk);
    start_md(3'd3, $urandom, $urandom, 1'b0, "rst_op");
    repeat (6) @(negedge clk);
    valid = 1'b1;
    rst   = 1'b1;
    #1;
    check("rst_mid stall", 32'(stall), 32'd0);
    check("rst_mid md_done", 32'(md_done), 32'd0);
    check("rst_mid md_result", md_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_restart stall_at_issue", 32'(stall), 32'd1);
    push_exp(3'd3, "rst_restart");
    wait_done("rst_restart", XLEN + 1);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
